// File: rtl/regfile_pkg.sv
// Shared defaults, controller state encoding and constants for the multi-port register file.
package regfile_pkg;

    localparam int unsigned DefDataW = 32;
    localparam int unsigned DefAddrW = 5;

    localparam logic [DefDataW-1:0] ZeroWord = '0;

    typedef enum logic {
        StClear,
        StReady
    } state_e;

endpackage

// File: rtl/regfile_rdport.sv
// One read port: write-bypass priority mux plus operand-pending flag.
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned NUM_WR = 2
) (
    input  logic                     active,
    input  logic                     re,
    input  logic [ADDR_W-1:0]        raddr,
    input  logic [NUM_WR-1:0]        we,
    input  logic [NUM_WR*ADDR_W-1:0] waddr,
    input  logic [NUM_WR*DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0]        entry,
    input  logic                     busy,
    output logic [DATA_W-1:0]        rdata,
    output logic                     rbusy
);

    localparam logic [DATA_W-1:0] Zero = DATA_W'(ZeroWord);

    logic              rd_en;
    logic              hit;
    logic [DATA_W-1:0] byp;

    assign rd_en = active & re & (raddr != '0);

    // Ascending scan so the highest-index matching write port wins.
    always_comb begin
        hit = 1'b0;
        byp = Zero;
        for (int i = 0; i < int'(NUM_WR); i++) begin
            if (we[i] && (waddr[i*ADDR_W +: ADDR_W] == raddr)) begin
                hit = 1'b1;
                byp = wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        rdata = Zero;
        if (rd_en) begin
            rdata = hit ? byp : entry;
        end
    end

    assign rbusy = rd_en & busy & ~hit;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with self-clearing start-up sequence, write bypass and busy scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned NUM_RD = 2,
    parameter int unsigned NUM_WR = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_WR-1:0]        we,
    input  logic [NUM_WR*ADDR_W-1:0] waddr,
    input  logic [NUM_WR*DATA_W-1:0] wdata,
    input  logic [NUM_RD-1:0]        re,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        rbusy,
    input  logic                     bset,
    input  logic [ADDR_W-1:0]        bset_addr,
    output logic                     ready
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [Depth-1:0]  busy_q, busy_d;
    logic [DATA_W-1:0] mem_q [Depth];
    logic              active;

    assign active = (state_q == StReady);
    assign ready  = active;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            StClear: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == ADDR_W'(Depth - 1)) begin
                    state_d = StReady;
                end
            end
            default: ;
        endcase
    end

    // Write-clear first, then bset, so a new producer keeps the entry busy.
    always_comb begin
        busy_d = busy_q;
        if (active) begin
            for (int i = 0; i < int'(NUM_WR); i++) begin
                if (we[i]) begin
                    busy_d[waddr[i*ADDR_W +: ADDR_W]] = 1'b0;
                end
            end
            if (bset) begin
                busy_d[bset_addr] = 1'b1;
            end
        end else begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StClear;
            clr_cnt_q <= '0;
            busy_q    <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            busy_q    <= busy_d;
        end
    end

    // Storage has no reset; its contents are defined only by the clear sequence.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == StClear) begin
                mem_q[clr_cnt_q] <= '0;
            end else begin
                for (int i = 0; i < int'(NUM_WR); i++) begin
                    if (we[i] && (waddr[i*ADDR_W +: ADDR_W] != '0)) begin
                        mem_q[waddr[i*ADDR_W +: ADDR_W]] <= wdata[i*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    for (genvar j = 0; j < int'(NUM_RD); j++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        assign ra = raddr[j*ADDR_W +: ADDR_W];

        regfile_rdport #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .NUM_WR (NUM_WR)
        ) u_rdport (
            .active (active),
            .re     (re[j]),
            .raddr  (ra),
            .we     (we),
            .waddr  (waddr),
            .wdata  (wdata),
            .entry  (mem_q[ra]),
            .busy   (busy_q[ra]),
            .rdata  (rdata[j*DATA_W +: DATA_W]),
            .rbusy  (rbusy[j])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: vector table for read/write/bypass/scoreboard, plus reset sequences.
module tb_regfile_mp;

    logic        clk;
    logic        rst;
    logic [1:0]  we;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic [1:0]  re;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  rbusy;
    logic        bset;
    logic [4:0]  bset_addr;
    logic        ready;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_mp #(
        .DATA_W (32),
        .ADDR_W (5),
        .NUM_RD (2),
        .NUM_WR (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .re        (re),
        .raddr     (raddr),
        .rdata     (rdata),
        .rbusy     (rbusy),
        .bset      (bset),
        .bset_addr (bset_addr),
        .ready     (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0, wa1;
        logic [31:0] wd0, wd1;
        logic [1:0]  re;
        logic [4:0]  ra0, ra1;
        logic        bs;
        logic [4:0]  ba;
        logic [31:0] e0, e1;
        logic [1:0]  eb;
    } vec_t;

    vec_t vecs [19];

    function automatic vec_t mk(logic [1:0] w, logic [4:0] wa0, logic [4:0] wa1,
                                logic [31:0] wd0, logic [31:0] wd1, logic [1:0] r,
                                logic [4:0] ra0, logic [4:0] ra1, logic bs, logic [4:0] ba,
                                logic [31:0] e0, logic [31:0] e1, logic [1:0] eb);
        vec_t v;
        v.we = w;   v.wa0 = wa0; v.wa1 = wa1; v.wd0 = wd0; v.wd1 = wd1;
        v.re = r;   v.ra0 = ra0; v.ra1 = ra1; v.bs = bs;   v.ba = ba;
        v.e0 = e0;  v.e1 = e1;   v.eb = eb;
        return v;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        we = 2'b00; waddr = '0; wdata = '0;
        re = 2'b00; raddr = '0;
        bset = 1'b0; bset_addr = '0;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        re = 2'b11; raddr = {a1, a0};
    endtask

    // Counts rising edges (starting from 'start') until ready; expects exactly 32.
    task automatic wait_ready(input string nm, input int start);
        int cycles;
        cycles = start;
        while (!ready && cycles < 40) begin
            @(posedge clk); #1;
            cycles++;
        end
        check(nm, 64'(cycles), 64'd32);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("ready in reset", 64'(ready), 64'd0);

        // Release reset; writes and bset issued during CLEAR must be ignored.
        @(negedge clk);
        rst = 1'b0;
        we = 2'b01; waddr = {5'd0, 5'd5}; wdata = {32'h0, 32'h1234};
        bset = 1'b1; bset_addr = 5'd5;
        rd(5'd5, 5'd5);
        #1;
        check("clear rdata", rdata, 64'd0);
        check("clear rbusy", 64'(rbusy), 64'd0);
        check("clear ready", 64'(ready), 64'd0);
        @(posedge clk); #1;
        idle_inputs();
        wait_ready("ready latency", 1);

        for (int a = 1; a < 32; a++) begin
            @(negedge clk);
            rd(5'(a), 5'(a));
            #1;
            check($sformatf("cleared entry %0d", a), rdata, 64'd0);
        end
        @(negedge clk);
        rd(5'd5, 5'd5);
        #1 check("no busy from CLEAR bset", 64'(rbusy), 64'd0);

        vecs[0]  = mk(2'b01, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0, 2'b10, 5'd0,  5'd5,  1'b0, 5'd0,
                      32'h0, 32'hDEADBEEF, 2'b00);
        vecs[1]  = mk(2'b00, 5'd0,  5'd0,  32'h0, 32'h0, 2'b11, 5'd5,  5'd0,  1'b0, 5'd0,
                      32'hDEADBEEF, 32'h0, 2'b00);
        vecs[2]  = mk(2'b11, 5'd7,  5'd7,  32'h11, 32'h22, 2'b11, 5'd7, 5'd5,  1'b0, 5'd0,
                      32'h22, 32'hDEADBEEF, 2'b00);
        vecs[3]  = mk(2'b00, 5'd0,  5'd0,  32'h0, 32'h0, 2'b11, 5'd7,  5'd7,  1'b0, 5'd0,
                      32'h22, 32'h22, 2'b00);
        vecs[4]  = mk(2'b01, 5'd0,  5'd0,  32'hFFFF, 32'h0, 2'b11, 5'd0, 5'd0, 1'b0, 5'd0,
                      32'h0, 32'h0, 2'b00);
        vecs[5]  = mk(2'b00, 5'd0,  5'd0,  32'h0, 32'h0, 2'b01, 5'd0,  5'd7,  1'b0, 5'd0,
                      32'h0, 32'h0, 2'b00);
        vecs[6]  = mk(2'b00, 5'd0,  5'd0,  32'h0, 32'h0, 2'b11, 5'd3,  5'd3,  1'b1, 5'd3,
                      32'h0, 32'h0, 2'b00);
        vecs[7]  = mk(2'b00, 5'd0,  5'd0,  32'h0, 32'h0, 2'b11, 5'd3,  5'd7,  1'b0, 5'd0,
                      32'h0, 32'h22, 2'b01);
        vecs[8]  = mk(2'b00, 5'd0,  5'd0,  32'h0, 32'h0, 2'b10, 5'd3,  5'd3,  1'b0, 5'd0,
                      32'h0, 32'h0, 2'b10);
        vecs[9]  = mk(2'b10, 5'd0,  5'd3,  32'h0, 32'h33, 2'b11, 5'd3, 5'd3,  1'b0, 5'd0,
                      32'h33, 32'h33, 2'b00);
        vecs[10] = mk(2'b00, 5'd0,  5'd0,  32'h0, 32'h0, 2'b11, 5'd3,  5'd3,  1'b0, 5'd0,
                      32'h33, 32'h33, 2'b00);
        vecs[11] = mk(2'b01, 5'd3,  5'd0,  32'h44, 32'h0, 2'b11, 5'd3, 5'd3,  1'b1, 5'd3,
                      32'h44, 32'h44, 2'b00);
        vecs[12] = mk(2'b00, 5'd0,  5'd0,  32'h0, 32'h0, 2'b11, 5'd3,  5'd3,  1'b0, 5'd0,
                      32'h44, 32'h44, 2'b11);
        vecs[13] = mk(2'b11, 5'd9,  5'd3,  32'h99, 32'h55, 2'b11, 5'd9, 5'd3,  1'b0, 5'd0,
                      32'h99, 32'h55, 2'b00);
        vecs[14] = mk(2'b00, 5'd0,  5'd0,  32'h0, 32'h0, 2'b11, 5'd9,  5'd3,  1'b0, 5'd0,
                      32'h99, 32'h55, 2'b00);
        vecs[15] = mk(2'b00, 5'd0,  5'd0,  32'h0, 32'h0, 2'b11, 5'd0,  5'd9,  1'b1, 5'd0,
                      32'h0, 32'h99, 2'b00);
        vecs[16] = mk(2'b00, 5'd0,  5'd0,  32'h0, 32'h0, 2'b11, 5'd0,  5'd31, 1'b0, 5'd0,
                      32'h0, 32'h0, 2'b00);
        vecs[17] = mk(2'b11, 5'd31, 5'd30, 32'hA5A5A5A5, 32'h5A5A5A5A, 2'b11, 5'd30, 5'd31,
                      1'b0, 5'd0, 32'h5A5A5A5A, 32'hA5A5A5A5, 2'b00);
        vecs[18] = mk(2'b00, 5'd0,  5'd0,  32'h0, 32'h0, 2'b11, 5'd30, 5'd31, 1'b0, 5'd0,
                      32'h5A5A5A5A, 32'hA5A5A5A5, 2'b00);

        for (int k = 0; k < 19; k++) begin
            @(negedge clk);
            we = vecs[k].we; waddr = {vecs[k].wa1, vecs[k].wa0};
            wdata = {vecs[k].wd1, vecs[k].wd0};
            re = vecs[k].re; raddr = {vecs[k].ra1, vecs[k].ra0};
            bset = vecs[k].bs; bset_addr = vecs[k].ba;
            #1;
            check($sformatf("v%0d rdata0", k), 64'(rdata[31:0]), 64'(vecs[k].e0));
            check($sformatf("v%0d rdata1", k), 64'(rdata[63:32]), 64'(vecs[k].e1));
            check($sformatf("v%0d rbusy", k), 64'(rbusy), 64'(vecs[k].eb));
        end

        // Mark 12 busy, then reset mid-operation and again mid-clear.
        @(negedge clk);
        idle_inputs();
        bset = 1'b1; bset_addr = 5'd12;
        @(negedge clk);
        idle_inputs();
        rd(5'd12, 5'd7);
        #1 check("busy 12 before reset", 64'(rbusy), 64'b01);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("ready after mid-op reset", 64'(ready), 64'd0);
        check("rdata in reset", rdata, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1 check("ready mid-clear", 64'(ready), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        wait_ready("ready after mid-clear reset", 0);
        @(negedge clk);
        rd(5'd12, 5'd7);
        #1;
        check("post-reset data", rdata, 64'd0);
        check("post-reset busy", 64'(rbusy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width; DEPTH = 2**ADDR_W entries.
REQ-003 SHALL have parameter NUM_RD, default 2, number of read ports.
REQ-004 SHALL have parameter NUM_WR, default 2, number of write ports.
REQ-005 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port we  input  NUM_WR  per-port write enable.
REQ-008 SHALL have port waddr  input  NUM_WR*ADDR_W  per-port write address, port i at bits [i*ADDR_W +: ADDR_W].
REQ-009 SHALL have port wdata  input  NUM_WR*DATA_W  per-port write data, same packing.
REQ-010 SHALL have port re  input  NUM_RD  per-port read enable.
REQ-011 SHALL have port raddr  input  NUM_RD*ADDR_W  per-port read address.
REQ-012 SHALL have port rdata  output  NUM_RD*DATA_W  per-port read data, combinational.
REQ-013 SHALL have port rbusy  output  NUM_RD  per-port "operand pending" flag, combinational.
REQ-014 SHALL have port bset  input  1  mark destination register busy (instruction issue).
REQ-015 SHALL have port bset_addr  input  ADDR_W  register to mark busy.
REQ-016 SHALL have port ready  output  1  high when clear sequence complete and file usable.

Function
REQ-017 SHALL run a two-state controller CLEAR -> READY; CLEAR entered on rst, READY after DEPTH clear cycles, READY held until next rst.
REQ-018 SHALL, in CLEAR, write zero to entry clr_cnt each cycle, clr_cnt counting 0..DEPTH-1, transition to READY on the cycle clr_cnt = DEPTH-1 is written.
REQ-019 SHALL drive ready = 0 in CLEAR, 1 in READY; first ready=1 exactly DEPTH cycles after rst deasserts.
REQ-020 SHALL ignore we and bset in CLEAR; rdata = 0 and rbusy = 0 on all ports in CLEAR.
REQ-021 SHALL, in READY, write wdata[i] to entry waddr[i] on rising edge when we[i]=1 and waddr[i] != 0.
REQ-022 SHALL keep entry 0 hard-wired to zero; writes to it discarded, reads return 0.
REQ-023 SHALL resolve simultaneous writes to the same address in favour of the highest-index port.
REQ-024 SHALL drive rdata[j] = 0 when re[j]=0 or raddr[j]=0.
REQ-025 SHALL bypass: when re[j]=1 and any we[i]=1 with waddr[i]=raddr[j]!=0, rdata[j] = wdata of highest-index matching port (same-cycle write visible, zero latency).
REQ-026 SHALL otherwise drive rdata[j] = stored entry raddr[j].
REQ-027 SHALL keep one busy bit per entry; bset=1 with bset_addr!=0 sets bit bset_addr on rising edge.
REQ-028 SHALL clear busy bit of every address written by any port on rising edge.
REQ-029 SHALL give set priority over clear when bset_addr equals a write address in the same cycle (new producer wins).
REQ-030 SHALL drive rbusy[j] = busy[raddr[j]] & re[j] & ~bypass_hit[j]; entry 0 never busy.

Reset
REQ-031 SHALL, on rst=1 at any rising edge (including mid-CLEAR or mid-operation), enter CLEAR, set clr_cnt = 0, clear all busy bits, drive ready = 0.
REQ-032 SHALL hold CLEAR with clr_cnt = 0 while rst remains high; clearing begins first cycle after rst falls.
REQ-033 SHALL not depend on power-up storage values; contents defined only through the clear sequence.

Structure
REQ-034 SHALL place default DATA_W/ADDR_W, state encoding (CLEAR, READY), and ZeroWord constant in shared package regfile_pkg.
REQ-035 SHALL implement per-read-port bypass/priority mux as sub-module regfile_rdport, instantiated NUM_RD times.

Verification
REQ-036 SHALL cover reset: rst 1 cycle, DEPTH=32 -> ready rises exactly 32 cycles later; all 31 nonzero entries read 0.
REQ-037 SHALL cover bypass: we[0]=1 waddr=5 wdata=0xDEADBEEF, raddr[1]=5 same cycle -> rdata[1]=0xDEADBEEF combinationally; next cycle stored value matches.
REQ-038 SHALL cover write conflict: we[0]=we[1]=1, both waddr=7, wdata 0x11/0x22 -> entry 7 = 0x22, same-cycle bypass = 0x22.
REQ-039 SHALL cover scoreboard: bset addr 3 -> rbusy for raddr 3 = 1; write addr 3 -> rbusy 0 that cycle via bypass, busy cleared next cycle; bset and write addr 3 same cycle -> busy stays 1.
REQ-040 SHALL cover entry 0 and reset mid-clear: write 0xFFFF to addr 0 -> reads 0; rst at clr_cnt=10 -> clr_cnt restarts 0, ready after full 32 cycles.
